oam_dma: RTL and testbench
==========================

// Module: oam_dma
// PURPOSE
//  Sprite DMA engine on the CPU bus, beside the cpu core and WRAM in cpu_toplevel.
//  A CPU write to $4014 with value P halts the CPU through the active-low rdy line.
//  The engine then copies the 256 bytes at WRAM $PP00-$PPFF into PPU OAMDATA ($2004,
//  PPU register 4) and releases the CPU.
//  While active, the engine owns the WRAM address bus and the PPU register port; toplevel muxes on dma_active.
// PARAMETERS
//  DMA_REG_ADDR   16'h4014  CPU address that triggers a transfer
//  OAM_DATA_REG   3'd4      PPU register index written per byte (OAMDATA)
//  XFER_BYTES     256       bytes per transfer (index counter wraps at this value)
// PORTS
//  clk            in   1   system clock, same domain as cpu/WRAM
//  reset          in   1   asynchronous, active-low reset
//  cpu_addr       in   16  CPU address bus (a_out)
//  cpu_data       in   8   CPU write data (d_out)
//  cpu_we         in   1   CPU write strobe (~r_nw_out), active high
//  rdy            out  1   to cpu ready_in; 0 halts CPU
//  dma_active     out  1   1 = engine owns WRAM addr bus and PPU port
//  dma_addr       out  16  WRAM read address {page, index}
//  wram_rdata     in   8   WRAM read data, valid 1 cycle after dma_addr (sync read)
//  ppu_reg_addr   out  3   PPU register index
//  ppu_wdata      out  8   data to PPU register
//  ppu_WE         out  1   PPU register write enable, active high
//  ppu_reg_cs     out  1   PPU register chip select, active low
// BEHAVIOUR
//  Reset (async, reset=0): state=IDLE, rdy=1, dma_active=0, dma_addr=0, ppu_reg_addr=0,
//   ppu_wdata=0, ppu_WE=0, ppu_reg_cs=1, page=0, index=0, parity=0.
//  parity: 1-bit toggle, flips every clk edge after reset; used only for alignment.
//  Trigger: edge where state==IDLE && cpu_we && cpu_addr==DMA_REG_ADDR.
//   On that edge: page<=cpu_data, index<=0, state<=HALT.
//  States and transitions:
//   IDLE : rdy=1, dma_active=0. Trigger -> HALT.
//   HALT : rdy=0, dma_active=0. One cycle for the CPU to finish its write.
//          Next: parity==1 -> ALIGN, else -> READ.
//   ALIGN: rdy=0, dma_active=1, no bus activity. One cycle -> READ.
//   READ : rdy=0, dma_active=1, dma_addr={page,index}, ppu_reg_cs=1. -> WRITE.
//   WRITE: rdy=0, dma_active=1, ppu_reg_cs=0, ppu_WE=1, ppu_reg_addr=OAM_DATA_REG,
//          ppu_wdata=wram_rdata (combinational pass-through).
//          index==XFER_BYTES-1 -> IDLE, else index<=index+1 -> READ.
//  PPU port outputs are Moore outputs of state; ppu_reg_cs=1 and ppu_WE=0 outside WRITE.
//  Latency: rdy falls the cycle after the trigger write.
//   rdy stays low for 1+A+512 cycles (A = 1 if ALIGN taken, else 0); total 513 or 514.
//  index is 8 bits and must not wrap into a second pass; the WRITE at 255 always ends.
//  page $FF is legal; addresses pass through unchanged, WRAM decoding is not our job.
//  Writes to DMA_REG_ADDR while state!=IDLE are ignored (CPU is halted anyway).
//   A write in the same cycle the engine returns to IDLE is also ignored.
//  Writes to other addresses never affect the engine.
//  Reset mid-transfer: immediate abort to reset values. Partial OAM contents are left as-is.
// STRUCTURE
//  Package cpu_bus_pkg: typedef enum logic [2:0] {IDLE,HALT,ALIGN,READ,WRITE} dma_state_t;
//   localparams PPU_OAMDATA=3'd4, APU_OAMDMA=16'h4014.
//  Single module, no sub-modules. Two always blocks: async-reset state/counter register,
//   combinational output decode. Toplevel muxes wram_addr / ppu port on dma_active.
// TESTING
//  1 Reset: hold reset=0 -> rdy=1, dma_active=0, ppu_reg_cs=1, ppu_WE=0.
//  2 Write $4014=8'h02 with parity=0 at HALT:
//     expect rdy=0 for 513 cycles, dma_addr $0200..$02FF in order,
//     256 OAMDATA writes with ppu_wdata==mem[$0200+i].
//  3 Same write with parity=1 at HALT: expect ALIGN inserted, rdy low for 514 cycles,
//     first READ one cycle later; data order unchanged.
//  4 Write $4015=8'h02 and $2004=8'h55 -> engine stays IDLE, rdy=1.
//     Second $4014 write mid-transfer -> ignored, page unchanged.
//  5 Assert reset at byte 100 of a $03 transfer -> next cycle rdy=1, ppu_reg_cs=1, state IDLE.
//     A new $4014=8'h04 then transfers from $0400.
//  6 Page $FF with mem[$FFxx]=xx -> last write is 8'hFF at index 255.
//     Engine returns to IDLE; no 257th write.

Source files
------------

// File: rtl/cpu_bus_pkg.sv
// Purpose: shared CPU-bus definitions for the sprite DMA engine.
//   dma_state_t  : engine FSM states
//   PPU_OAMDATA  : PPU register index of OAMDATA
//   APU_OAMDMA   : CPU address that starts a sprite DMA
//   OAM_XFER_LEN : bytes copied per sprite DMA
package cpu_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        READ,
        WRITE
    } dma_state_t;

    localparam logic [2:0]  PPU_OAMDATA  = 3'd4;
    localparam logic [15:0] APU_OAMDMA   = 16'h4014;
    localparam int unsigned OAM_XFER_LEN = 256;

endpackage

// File: rtl/oam_dma.sv
// Purpose: sprite DMA engine. A CPU write of P to DMA_REG_ADDR halts the CPU
// and copies WRAM $PP00-$PPFF into the PPU OAMDATA register, one byte per
// READ/WRITE pair. One extra ALIGN cycle is inserted when the halt lands on
// an odd parity cycle.
// Ports:
//   clk          in   system clock (cpu/WRAM domain)
//   reset        in   asynchronous reset, active low
//   cpu_addr     in   CPU address bus
//   cpu_data     in   CPU write data
//   cpu_we       in   CPU write strobe, active high
//   rdy          out  CPU ready; 0 halts the CPU
//   dma_active   out  engine owns the WRAM address bus and PPU port
//   dma_addr     out  WRAM read address {page, index}
//   wram_rdata   in   WRAM read data, one cycle after dma_addr
//   ppu_reg_addr out  PPU register index
//   ppu_wdata    out  PPU register write data
//   ppu_WE       out  PPU register write enable, active high
//   ppu_reg_cs   out  PPU register chip select, active low
module oam_dma
    import cpu_bus_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR = APU_OAMDMA,
    parameter logic [2:0]  OAM_DATA_REG = PPU_OAMDATA,
    parameter int unsigned XFER_BYTES   = OAM_XFER_LEN
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data,
    input  logic        cpu_we,
    output logic        rdy,
    output logic        dma_active,
    output logic [15:0] dma_addr,
    input  logic [7:0]  wram_rdata,
    output logic [2:0]  ppu_reg_addr,
    output logic [7:0]  ppu_wdata,
    output logic        ppu_WE,
    output logic        ppu_reg_cs
);

    localparam logic [7:0] LAST_INDEX = 8'(XFER_BYTES - 1);

    dma_state_t r_state;
    logic [7:0] r_page;
    logic [7:0] r_index;
    logic       r_parity;
    logic       w_trigger;

    // Only IDLE accepts a trigger, so a write landing on the WRITE->IDLE
    // edge or anywhere mid-transfer is dropped without extra logic.
    assign w_trigger = (r_state == IDLE) && cpu_we && (cpu_addr == DMA_REG_ADDR);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_page   <= '0;
            r_index  <= '0;
            r_parity <= 1'b0;
        end else begin
            r_parity <= ~r_parity;
            case (r_state)
                IDLE: begin
                    if (w_trigger) begin
                        r_page  <= cpu_data;
                        r_index <= '0;
                        r_state <= HALT;
                    end
                end
                HALT: begin
                    r_state <= r_parity ? ALIGN : READ;
                end
                ALIGN: begin
                    r_state <= READ;
                end
                READ: begin
                    r_state <= WRITE;
                end
                WRITE: begin
                    // The last byte always terminates; index never wraps
                    // into a second pass.
                    if (r_index == LAST_INDEX) begin
                        r_state <= IDLE;
                    end else begin
                        r_index <= r_index + 8'd1;
                        r_state <= READ;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        rdy          = 1'b1;
        dma_active   = 1'b0;
        dma_addr     = {r_page, r_index};
        ppu_reg_addr = '0;
        ppu_wdata    = '0;
        ppu_WE       = 1'b0;
        ppu_reg_cs   = 1'b1;
        case (r_state)
            IDLE: begin
                rdy = 1'b1;
            end
            HALT: begin
                rdy = 1'b0;
            end
            ALIGN, READ: begin
                rdy        = 1'b0;
                dma_active = 1'b1;
            end
            WRITE: begin
                rdy          = 1'b0;
                dma_active   = 1'b1;
                ppu_reg_cs   = 1'b0;
                ppu_WE       = 1'b1;
                ppu_reg_addr = OAM_DATA_REG;
                // WRAM read issued in READ arrives now; forward unregistered.
                ppu_wdata    = wram_rdata;
            end
            default: begin
                rdy = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: reset values, aligned/unaligned transfers,
// ignored writes, mid-transfer reset and the $FF page boundary.
module tb_oam_dma;

    logic        clk;
    logic        reset;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data;
    logic        cpu_we;
    logic        rdy;
    logic        dma_active;
    logic [15:0] dma_addr;
    logic [7:0]  wram_rdata;
    logic [2:0]  ppu_reg_addr;
    logic [7:0]  ppu_wdata;
    logic        ppu_WE;
    logic        ppu_reg_cs;

    logic [7:0]  mem [0:65535];
    logic        mpar;
    logic [7:0]  last_wdata;
    int          n_chk;
    int          n_pass;
    int          n_fail;

    oam_dma #(
        .DMA_REG_ADDR (16'h4014),
        .OAM_DATA_REG (3'd4),
        .XFER_BYTES   (256)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_addr     (cpu_addr),
        .cpu_data     (cpu_data),
        .cpu_we       (cpu_we),
        .rdy          (rdy),
        .dma_active   (dma_active),
        .dma_addr     (dma_addr),
        .wram_rdata   (wram_rdata),
        .ppu_reg_addr (ppu_reg_addr),
        .ppu_wdata    (ppu_wdata),
        .ppu_WE       (ppu_WE),
        .ppu_reg_cs   (ppu_reg_cs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read WRAM model.
    always @(posedge clk) wram_rdata <= mem[dma_addr];

    // Reference parity: toggles every edge out of reset.
    always @(posedge clk or negedge reset) begin
        if (!reset) mpar <= 1'b0;
        else        mpar <= ~mpar;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start a transfer of 'page' so that ALIGN is taken iff want_align,
    // then follow it to completion checking every OAM write.
    // inject: issue a second $4014 write mid-transfer.
    // abort_at: byte index at which reset is pulsed (-1 = never).
    task automatic xfer(input logic [7:0] page, input logic want_align,
                        input bit inject, input int abort_at);
        int  nlow;
        int  nwr;
        int  first_wr;
        bit  done;
        logic [7:0] idx;
        // HALT sees the parity after the trigger edge, i.e. ~mpar now.
        if (mpar != !want_align) step();
        cpu_addr = 16'h4014;
        cpu_data = page;
        cpu_we   = 1'b1;
        step();
        cpu_we   = 1'b0;
        cpu_addr = 16'h0000;
        cpu_data = 8'h00;
        chk("halt_rdy", 32'(rdy), 32'd0);
        chk("halt_active", 32'(dma_active), 32'd0);
        nlow = 0;
        nwr = 0;
        first_wr = -1;
        done = 1'b0;
        for (int k = 0; k < 600 && !done; k++) begin
            if (rdy) begin
                done = 1'b1;
            end else begin
                nlow++;
                if (inject && k == 50) begin
                    cpu_addr = 16'h4014;
                    cpu_data = 8'h07;
                    cpu_we   = 1'b1;
                end else if (inject && k == 51) begin
                    cpu_we   = 1'b0;
                    cpu_addr = 16'h0000;
                    cpu_data = 8'h00;
                end
                if (ppu_WE) begin
                    idx = nwr[7:0];
                    if (first_wr < 0) first_wr = k;
                    chk("wr_dma_addr", 32'(dma_addr), 32'({page, idx}));
                    chk("wr_data", 32'(ppu_wdata), 32'(mem[{page, idx}]));
                    chk("wr_reg", 32'(ppu_reg_addr), 32'd4);
                    chk("wr_cs", 32'(ppu_reg_cs), 32'd0);
                    last_wdata = ppu_wdata;
                    if (nwr == abort_at) begin
                        reset = 1'b0;
                        #1;
                        chk("abort_rdy", 32'(rdy), 32'd1);
                        chk("abort_cs", 32'(ppu_reg_cs), 32'd1);
                        chk("abort_we", 32'(ppu_WE), 32'd0);
                        chk("abort_active", 32'(dma_active), 32'd0);
                        chk("abort_addr", 32'(dma_addr), 32'd0);
                        step();
                        chk("abort_rdy_next", 32'(rdy), 32'd1);
                        chk("abort_cs_next", 32'(ppu_reg_cs), 32'd1);
                        reset = 1'b1;
                        step();
                        return;
                    end
                    nwr++;
                end
                step();
            end
        end
        chk("xfer_done", 32'(done), 32'd1);
        chk("rdy_low_cycles", 32'(nlow), want_align ? 32'd514 : 32'd513);
        chk("first_write", 32'(first_wr), want_align ? 32'd3 : 32'd2);
        chk("write_count", 32'(nwr), 32'd256);
        chk("idle_active", 32'(dma_active), 32'd0);
        step();
        step();
        chk("no_extra_write", 32'(ppu_WE), 32'd0);
        chk("idle_rdy", 32'(rdy), 32'd1);
    endtask

    initial begin
        logic [15:0] av;
        n_chk = 0;
        n_pass = 0;
        n_fail = 0;
        last_wdata = 8'h00;
        for (int unsigned a = 0; a < 65536; a++) begin
            av = 16'(a);
            if (av[15:8] == 8'hFF) mem[av] = av[7:0];
            else                   mem[av] = 8'(av[7:0] * 8'd7) ^ av[15:8] ^ 8'hA5;
        end
        cpu_addr = 16'h0000;
        cpu_data = 8'h00;
        cpu_we   = 1'b0;
        reset    = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdy", 32'(rdy), 32'd1);
        chk("rst_active", 32'(dma_active), 32'd0);
        chk("rst_cs", 32'(ppu_reg_cs), 32'd1);
        chk("rst_we", 32'(ppu_WE), 32'd0);
        chk("rst_dma_addr", 32'(dma_addr), 32'd0);
        chk("rst_reg", 32'(ppu_reg_addr), 32'd0);
        chk("rst_wdata", 32'(ppu_wdata), 32'd0);
        reset = 1'b1;
        step();

        // Page $02, no alignment cycle
        xfer(8'h02, 1'b0, 1'b0, -1);
        // Page $02, alignment cycle inserted
        xfer(8'h02, 1'b1, 1'b0, -1);

        // Writes to other addresses leave the engine idle
        cpu_addr = 16'h4015;
        cpu_data = 8'h02;
        cpu_we   = 1'b1;
        step();
        chk("4015_rdy", 32'(rdy), 32'd1);
        cpu_addr = 16'h2004;
        cpu_data = 8'h55;
        step();
        chk("2004_rdy", 32'(rdy), 32'd1);
        cpu_we   = 1'b0;
        cpu_addr = 16'h0000;
        cpu_data = 8'h00;
        step();
        chk("other_rdy", 32'(rdy), 32'd1);
        chk("other_active", 32'(dma_active), 32'd0);
        chk("other_we", 32'(ppu_WE), 32'd0);

        // Second $4014 write mid-transfer is ignored
        xfer(8'h05, 1'b0, 1'b1, -1);

        // Reset at byte 100 of a $03 transfer, then a clean $04 transfer
        xfer(8'h03, 1'b0, 1'b0, 100);
        xfer(8'h04, 1'b1, 1'b0, -1);

        // Page $FF boundary
        xfer(8'hFF, 1'b1, 1'b0, -1);
        chk("ff_last_data", 32'(last_wdata), 32'hFF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
